jtag_userop_sequencer: RTL and testbench

- Command sequencer that sits behind the TAP's USEROP and USERDATA registers, in the tck domain.
- Decodes each completed user opcode into single-beat transactions on a simple req/ack register bus, with an auto-incrementing address pointer.
- Drives the read result or a status word back into the USERDATA capture path, so the host reads it on the next Capture-DR.
- Host protocol: shift USERDATA (operand), shift USEROP (opcode), clock Run-Test/Idle, then read back USERDATA.

---
 rtl/jtag_userop_pkg.sv | 73 +++++++
 rtl/jtag_seq_timer.sv | 43 ++++
 rtl/jtag_userop_sequencer.sv | 292 +++++++++++++++++++++++++++++
 tb/tb_jtag_userop_sequencer.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jtag_userop_pkg.sv
// -----------------------------------------------------------------------------
// jtag_userop_pkg
// Shared definitions for the JTAG user-opcode sequencer:
//   - user opcode encodings
//   - sequencer FSM state encoding
//   - sticky status flags and status word bit positions
//   - all-ones constant returned by a read that times out
//   - small helpers to classify opcodes and assemble the status word
// -----------------------------------------------------------------------------
package jtag_userop_pkg;

    // User opcodes (low 8 bits of USEROP; higher bits must be zero).
    localparam logic [7:0] OP_NOP        = 8'h00;
    localparam logic [7:0] OP_SET_ADDR   = 8'h01;
    localparam logic [7:0] OP_WRITE      = 8'h02;
    localparam logic [7:0] OP_READ       = 8'h03;
    localparam logic [7:0] OP_WRITE_INC  = 8'h04;
    localparam logic [7:0] OP_READ_INC   = 8'h05;
    localparam logic [7:0] OP_GET_STATUS = 8'h06;
    localparam logic [7:0] OP_CLR_STATUS = 8'h07;

    // Sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_DONE = 2'd2
    } seq_state_e;

    // Status word bit positions.
    localparam int STAT_BUSY    = 0;
    localparam int STAT_ERR     = 1;
    localparam int STAT_TIMEOUT = 2;
    localparam int STAT_ILLEGAL = 3;
    localparam int STAT_OVERRUN = 4;
    localparam int STAT_OP_LSB  = 8;

    // Widest data path supported by the all-ones constant below.
    localparam int MAX_DATA_W = 1024;

    // Value returned in place of read data when the bus never acknowledges.
    localparam logic [MAX_DATA_W-1:0] ALL_ONES = '1;

    // Sticky flags, cleared only by CLR_STATUS or reset.
    typedef struct packed {
        logic overrun;
        logic illegal;
        logic timeout;
        logic err;
    } sticky_flags_t;

    function automatic logic op_is_read(input logic [7:0] op);
        return (op == OP_READ) || (op == OP_READ_INC);
    endfunction

    function automatic logic op_is_inc(input logic [7:0] op);
        return (op == OP_WRITE_INC) || (op == OP_READ_INC);
    endfunction

    function automatic logic [15:0] pack_status(input logic          busy,
                                                input sticky_flags_t flags,
                                                input logic [7:0]    last_op);
        logic [15:0] s;
        s                     = '0;
        s[STAT_BUSY]          = busy;
        s[STAT_ERR]           = flags.err;
        s[STAT_TIMEOUT]       = flags.timeout;
        s[STAT_ILLEGAL]       = flags.illegal;
        s[STAT_OVERRUN]       = flags.overrun;
        s[STAT_OP_LSB +: 8]   = last_op;
        return s;
    endfunction

endpackage

// File: rtl/jtag_seq_timer.sv
// -----------------------------------------------------------------------------
// jtag_seq_timer
// Loadable down-counter used as the bus-acknowledge watchdog.
// Ports:
//   i_clk       clock
//   i_rst_n     asynchronous active-low reset
//   i_load      load i_load_val (ignored while i_clear is high)
//   i_load_val  value loaded on i_load
//   i_clear     force the count to zero (highest priority)
//   i_en        count down by one; holds at zero
//   o_tc        terminal count: the counter is zero
// -----------------------------------------------------------------------------
module jtag_seq_timer #(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_clear,
    input  logic             i_en,
    output logic             o_tc
);

    logic [WIDTH-1:0] r_count;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of block ordering.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_en && (r_count != '0)) begin
            r_count <= r_count - WIDTH'(1);
        end
    end

    assign o_tc = (r_count == '0);

endmodule

// File: rtl/jtag_userop_sequencer.sv
// -----------------------------------------------------------------------------
// jtag_userop_sequencer
// Turns completed USEROP/USERDATA shifts into single-beat transactions on a
// req/ack register bus, with an auto-incrementing address pointer, and
// presents read data or a status word for the next USERDATA Capture-DR.
// Everything runs in the tck domain.
// Ports:
//   tck           TAP clock (only clock)
//   trst          asynchronous active-low reset
//   userop        opcode from the USEROP register
//   userop_ready  one-cycle pulse at Update-DR of USEROP
//   userdata_out  operand shifted in by the host
//   userdata_in   value captured by the next USERDATA Capture-DR
//   bus_req       transaction request, held until ack or timeout
//   bus_we        1 = write, 0 = read
//   bus_addr      transaction address (pointer value at issue)
//   bus_wdata     write data (operand latched with the opcode)
//   bus_rdata     read data, valid with bus_ack
//   bus_ack       completion strobe, honoured only while bus_req is high
//   bus_err       error flag, sampled only with bus_ack
//   busy          a transaction is in flight (state != IDLE)
// ADDR_W must not exceed USERDATA_LEN; USERDATA_LEN must not exceed
// MAX_DATA_W from the package.
// -----------------------------------------------------------------------------
module jtag_userop_sequencer
    import jtag_userop_pkg::*;
#(
    parameter int USERDATA_LEN   = 32,
    parameter int USEROP_LEN     = 8,
    parameter int ADDR_W         = 16,
    parameter int ADDR_STRIDE    = 1,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                    tck,
    input  logic                    trst,
    input  logic [USEROP_LEN-1:0]   userop,
    input  logic                    userop_ready,
    input  logic [USERDATA_LEN-1:0] userdata_out,
    output logic [USERDATA_LEN-1:0] userdata_in,
    output logic                    bus_req,
    output logic                    bus_we,
    output logic [ADDR_W-1:0]       bus_addr,
    output logic [USERDATA_LEN-1:0] bus_wdata,
    input  logic [USERDATA_LEN-1:0] bus_rdata,
    input  logic                    bus_ack,
    input  logic                    bus_err,
    output logic                    busy
);

    // The watchdog is loaded with TIMEOUT_CYCLES-1 so that terminal count is
    // reached on the TIMEOUT_CYCLES-th cycle with bus_req high.
    localparam int               TMR_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT_CYCLES - 1);

    // ---------------------------------------------------------------------
    // Declarations
    // ---------------------------------------------------------------------
    seq_state_e                r_state;
    seq_state_e                w_state_nxt;

    logic                      r_bus_req;
    logic                      r_bus_we;
    logic [ADDR_W-1:0]         r_bus_addr;
    logic [USERDATA_LEN-1:0]   r_bus_wdata;
    logic [ADDR_W-1:0]         r_ptr;
    logic [USERDATA_LEN-1:0]   r_userdata_in;
    logic [7:0]                r_last_op;
    sticky_flags_t             r_flags;
    sticky_flags_t             w_flags_nxt;

    // Outcome of the bus beat, captured when it ends and applied in DONE.
    logic                      r_rsp_ok;
    logic                      r_rsp_err;
    logic [USERDATA_LEN-1:0]   r_rsp_data;

    logic [USEROP_LEN+7:0]     w_op_ext;
    logic [7:0]                w_op8;
    logic                      w_op_legal;
    logic                      w_is_bus;
    logic                      w_is_write;
    logic                      w_is_set_addr;
    logic                      w_is_get_status;
    logic                      w_is_clr_status;
    logic                      w_is_illegal;

    logic                      w_busy;
    logic                      w_accept;
    logic                      w_overrun;
    logic                      w_start;
    logic                      w_ack;
    logic                      w_tc;
    logic                      w_timeout;
    logic                      w_complete;
    logic                      w_tmr_en;
    logic                      w_tmr_clear;

    // ---------------------------------------------------------------------
    // Opcode decode
    // ---------------------------------------------------------------------
    // Zero-padding by 8 lets the same slices work for any USEROP_LEN: the
    // low byte is the opcode and every bit above it must be zero.
    assign w_op_ext   = {8'd0, userop};
    assign w_op8      = w_op_ext[7:0];
    assign w_op_legal = (w_op_ext[USEROP_LEN+7:8] == '0) && (w_op8 <= OP_CLR_STATUS);

    // NOTE: every output of a combinational block gets a default first, so
    // no path through the block can leave a value held (no latch inferred).
    always_comb begin
        w_is_bus        = 1'b0;
        w_is_write      = 1'b0;
        w_is_set_addr   = 1'b0;
        w_is_get_status = 1'b0;
        w_is_clr_status = 1'b0;
        w_is_illegal    = 1'b0;
        if (!w_op_legal) begin
            w_is_illegal = 1'b1;
        end else begin
            case (w_op8)
                OP_SET_ADDR:               w_is_set_addr   = 1'b1;
                OP_GET_STATUS:             w_is_get_status = 1'b1;
                OP_CLR_STATUS:             w_is_clr_status = 1'b1;
                OP_WRITE, OP_WRITE_INC: begin
                    w_is_bus   = 1'b1;
                    w_is_write = 1'b1;
                end
                OP_READ, OP_READ_INC:      w_is_bus        = 1'b1;
                default: ;                 // OP_NOP
            endcase
        end
    end

    // ---------------------------------------------------------------------
    // Control strobes
    // ---------------------------------------------------------------------
    assign w_busy     = (r_state != ST_IDLE);
    assign w_accept   = userop_ready && !w_busy;
    assign w_overrun  = userop_ready &&  w_busy;
    assign w_start    = w_accept && w_is_bus;
    // An ack arriving while bus_req is low is not ours and is dropped.
    assign w_ack      = (r_state == ST_BUS) && r_bus_req && bus_ack;
    // Ack wins over a coincident timeout.
    assign w_timeout  = (r_state == ST_BUS) && r_bus_req && !bus_ack && w_tc;
    assign w_complete = (r_state == ST_DONE);

    assign w_tmr_en    = (r_state == ST_BUS) && r_bus_req;
    assign w_tmr_clear = w_ack || w_timeout;

    jtag_seq_timer #(
        .WIDTH      (TMR_W)
    ) u_timer (
        .i_clk      (tck),
        .i_rst_n    (trst),
        .i_load     (w_start),
        .i_load_val (TMR_LOAD),
        .i_clear    (w_tmr_clear),
        .i_en       (w_tmr_en),
        .o_tc       (w_tc)
    );

    // ---------------------------------------------------------------------
    // FSM: IDLE -> BUS -> DONE -> IDLE
    // ---------------------------------------------------------------------
    always_ff @(posedge tck or negedge trst) begin
        if (!trst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_start)               w_state_nxt = ST_BUS;
            ST_BUS:  if (w_ack || w_timeout)    w_state_nxt = ST_DONE;
            ST_DONE:                            w_state_nxt = ST_IDLE;
            default:                            w_state_nxt = ST_IDLE;
        endcase
    end

    // ---------------------------------------------------------------------
    // Bus request channel: address/data/direction stay frozen for the beat.
    // ---------------------------------------------------------------------
    always_ff @(posedge tck or negedge trst) begin
        if (!trst) begin
            r_bus_req   <= 1'b0;
            r_bus_we    <= 1'b0;
            r_bus_addr  <= '0;
            r_bus_wdata <= '0;
        end else if (w_start) begin
            r_bus_req   <= 1'b1;
            r_bus_we    <= w_is_write;
            r_bus_addr  <= r_ptr;
            r_bus_wdata <= userdata_out;
        end else if (w_ack || w_timeout) begin
            r_bus_req   <= 1'b0;
        end
    end

    // ---------------------------------------------------------------------
    // Beat outcome capture (rdata is only valid in the ack cycle).
    // ---------------------------------------------------------------------
    always_ff @(posedge tck or negedge trst) begin
        if (!trst) begin
            r_rsp_ok   <= 1'b0;
            r_rsp_err  <= 1'b0;
            r_rsp_data <= '0;
        end else if (w_ack) begin
            r_rsp_ok   <= 1'b1;
            r_rsp_err  <= bus_err;
            r_rsp_data <= bus_rdata;
        end else if (w_timeout) begin
            r_rsp_ok   <= 1'b0;
            r_rsp_err  <= 1'b0;
            r_rsp_data <= ALL_ONES[USERDATA_LEN-1:0];
        end
    end

    // ---------------------------------------------------------------------
    // Address pointer: loaded by SET_ADDR, advanced after a clean *_INC beat.
    // The add wraps naturally at ADDR_W bits.
    // ---------------------------------------------------------------------
    always_ff @(posedge tck or negedge trst) begin
        if (!trst) begin
            r_ptr <= '0;
        end else if (w_accept && w_is_set_addr) begin
            r_ptr <= userdata_out[ADDR_W-1:0];
        end else if (w_complete && r_rsp_ok && !r_rsp_err && op_is_inc(r_last_op)) begin
            r_ptr <= r_ptr + ADDR_W'(ADDR_STRIDE);
        end
    end

    // ---------------------------------------------------------------------
    // Capture value for the host. The status word reflects the state before
    // the GET_STATUS itself, so its opcode field is the previous command.
    // ---------------------------------------------------------------------
    always_ff @(posedge tck or negedge trst) begin
        if (!trst) begin
            r_userdata_in <= '0;
        end else if (w_accept && w_is_get_status) begin
            r_userdata_in <= USERDATA_LEN'(pack_status(w_busy, r_flags, r_last_op));
        end else if (w_complete && op_is_read(r_last_op)) begin
            r_userdata_in <= r_rsp_data;
        end
    end

    // ---------------------------------------------------------------------
    // Sticky flags and last accepted opcode. An overrun pulse is dropped
    // without touching the opcode history.
    // ---------------------------------------------------------------------
    always_comb begin
        w_flags_nxt = r_flags;
        if (w_accept && w_is_clr_status) begin
            w_flags_nxt = '0;
        end
        if (w_accept && w_is_illegal) begin
            w_flags_nxt.illegal = 1'b1;
        end
        if (w_overrun) begin
            w_flags_nxt.overrun = 1'b1;
        end
        if (w_timeout) begin
            w_flags_nxt.timeout = 1'b1;
        end
        if (w_complete && r_rsp_ok && r_rsp_err) begin
            w_flags_nxt.err = 1'b1;
        end
    end

    always_ff @(posedge tck or negedge trst) begin
        if (!trst) begin
            r_flags   <= '0;
            r_last_op <= '0;
        end else begin
            r_flags <= w_flags_nxt;
            if (w_accept) begin
                r_last_op <= w_op8;
            end
        end
    end

    // ---------------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------------
    assign userdata_in = r_userdata_in;
    assign bus_req     = r_bus_req;
    assign bus_we      = r_bus_we;
    assign bus_addr    = r_bus_addr;
    assign bus_wdata   = r_bus_wdata;
    assign busy        = w_busy;

endmodule

// File: tb/tb_jtag_userop_sequencer.sv
// -----------------------------------------------------------------------------
// tb_jtag_userop_sequencer
// Directed and randomized host commands against jtag_userop_sequencer, with a
// command-level reference model (pointer, sticky flags, last opcode, capture
// value) and a bus responder driven inline.
// -----------------------------------------------------------------------------
module tb_jtag_userop_sequencer;

    localparam int DW     = 32;
    localparam int OPW    = 8;
    localparam int AW     = 16;
    localparam int STRIDE = 1;
    localparam int TO     = 255;

    localparam logic [7:0] C_NOP        = 8'h00;
    localparam logic [7:0] C_SET_ADDR   = 8'h01;
    localparam logic [7:0] C_WRITE      = 8'h02;
    localparam logic [7:0] C_READ       = 8'h03;
    localparam logic [7:0] C_WRITE_INC  = 8'h04;
    localparam logic [7:0] C_READ_INC   = 8'h05;
    localparam logic [7:0] C_GET_STATUS = 8'h06;
    localparam logic [7:0] C_CLR_STATUS = 8'h07;

    logic            tck          = 1'b0;
    logic            trst         = 1'b1;
    logic [OPW-1:0]  userop       = '0;
    logic            userop_ready = 1'b0;
    logic [DW-1:0]   userdata_out = '0;
    logic [DW-1:0]   userdata_in;
    logic            bus_req;
    logic            bus_we;
    logic [AW-1:0]   bus_addr;
    logic [DW-1:0]   bus_wdata;
    logic [DW-1:0]   bus_rdata    = '0;
    logic            bus_ack      = 1'b0;
    logic            bus_err      = 1'b0;
    logic            busy;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state.
    logic [AW-1:0] m_ptr     = '0;
    logic [DW-1:0] m_ud      = '0;
    logic [7:0]    m_last    = '0;
    bit            m_err     = 1'b0;
    bit            m_timeout = 1'b0;
    bit            m_illegal = 1'b0;
    bit            m_overrun = 1'b0;

    jtag_userop_sequencer #(
        .USERDATA_LEN   (DW),
        .USEROP_LEN     (OPW),
        .ADDR_W         (AW),
        .ADDR_STRIDE    (STRIDE),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .tck          (tck),
        .trst         (trst),
        .userop       (userop),
        .userop_ready (userop_ready),
        .userdata_out (userdata_out),
        .userdata_in  (userdata_in),
        .bus_req      (bus_req),
        .bus_we       (bus_we),
        .bus_addr     (bus_addr),
        .bus_wdata    (bus_wdata),
        .bus_rdata    (bus_rdata),
        .bus_ack      (bus_ack),
        .bus_err      (bus_err),
        .busy         (busy)
    );

    always #5 tck = ~tck;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d", n_checks);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] model_status();
        return {16'h0000, m_last, 3'b000, m_overrun, m_illegal, m_timeout, m_err, 1'b0};
    endfunction

    task automatic model_accept(input logic [7:0] op, input logic [DW-1:0] operand);
        if (op == C_SET_ADDR) begin
            m_ptr = operand[AW-1:0];
        end else if (op == C_GET_STATUS) begin
            m_ud = model_status();
        end else if (op == C_CLR_STATUS) begin
            m_err = 0; m_timeout = 0; m_illegal = 0; m_overrun = 0;
        end else if (op > C_CLR_STATUS) begin
            m_illegal = 1;
        end
        m_last = op;
    endtask

    task automatic model_finish(input logic [7:0] op, input bit acked,
                                input bit err, input logic [DW-1:0] rdata);
        bit is_read;
        bit is_inc;
        is_read = (op == C_READ) || (op == C_READ_INC);
        is_inc  = (op == C_WRITE_INC) || (op == C_READ_INC);
        if (acked) begin
            if (is_read) m_ud = rdata;
            if (err) m_err = 1;
            else if (is_inc) m_ptr = m_ptr + AW'(STRIDE);
        end else begin
            m_timeout = 1;
            if (is_read) m_ud = '1;
        end
    endtask

    // One host command. ack_at = cycle (1-based, counted with bus_req high)
    // in which the responder acks; 0 = never. ovr pulses userop_ready in the
    // first bus cycle.
    task automatic run_op(input logic [7:0] op, input logic [DW-1:0] operand,
                          input int ack_at, input bit err_in,
                          input logic [DW-1:0] rdata, input bit ovr);
        logic [AW-1:0] exp_addr;
        bit            is_bus;
        bit            is_wr;
        bit            done;
        int            cyc;
        @(negedge tck);
        userop       = op;
        userdata_out = operand;
        userop_ready = 1'b1;
        exp_addr     = m_ptr;
        is_bus       = (op >= C_WRITE) && (op <= C_READ_INC);
        is_wr        = (op == C_WRITE) || (op == C_WRITE_INC);
        model_accept(op, operand);
        @(negedge tck);
        userop_ready = 1'b0;
        if (!is_bus) begin
            check("nb_busy", busy, 0);
            check("nb_req", bus_req, 0);
            check("nb_userdata_in", userdata_in, m_ud);
            return;
        end
        cyc  = 0;
        done = 0;
        while (!done) begin
            cyc++;
            check("bus_req_held", bus_req, 1);
            check("bus_addr", bus_addr, exp_addr);
            check("bus_we", bus_we, is_wr);
            check("bus_wdata", bus_wdata, operand);
            check("busy_in_bus", busy, 1);
            if (ovr && cyc == 1) begin
                userop       = C_WRITE;
                userop_ready = 1'b1;
                m_overrun    = 1;
            end
            if (ack_at == cyc) begin
                bus_ack   = 1'b1;
                bus_err   = err_in;
                bus_rdata = rdata;
            end
            @(negedge tck);
            userop_ready = 1'b0;
            bus_ack      = 1'b0;
            bus_err      = 1'b0;
            done = (ack_at == cyc) || (cyc == TO);
        end
        model_finish(op, ack_at == cyc, err_in, rdata);
        check("req_dropped", bus_req, 0);
        check("busy_in_done", busy, 1);
        @(negedge tck);
        check("busy_after", busy, 0);
        check("req_after", bus_req, 0);
        check("userdata_in_after", userdata_in, m_ud);
    endtask

    initial begin
        logic [7:0]    op;
        logic [DW-1:0] rd;

        // Reset state.
        #3 trst = 1'b0;
        #4;
        check("rst_userdata_in", userdata_in, 0);
        check("rst_bus_req", bus_req, 0);
        check("rst_bus_we", bus_we, 0);
        check("rst_bus_addr", bus_addr, 0);
        check("rst_bus_wdata", bus_wdata, 0);
        check("rst_busy", busy, 0);
        repeat (2) @(negedge tck);
        trst = 1'b1;

        // Write with increment, ack in the 3rd cycle.
        run_op(C_SET_ADDR, 32'h0000_0010, 0, 0, 0, 0);
        run_op(C_WRITE_INC, 32'hCAFE_F00D, 3, 0, 0, 0);

        // Read at the incremented address.
        run_op(C_READ, 32'h0, 2, 0, 32'h1234_5678, 0);
        check("read_data", userdata_in, 32'h1234_5678);

        // Read that never gets acked.
        run_op(C_READ, 32'h0, 0, 0, 0, 0);
        check("timeout_data", userdata_in, 32'hFFFF_FFFF);
        run_op(C_GET_STATUS, 32'h0, 0, 0, 0, 0);
        check("status_timeout", userdata_in, 32'h0000_0304);

        // Errored write with increment: pointer must not advance.
        run_op(C_WRITE_INC, 32'h1111_2222, 2, 1, 0, 0);
        run_op(C_GET_STATUS, 32'h0, 0, 0, 0, 0);
        check("status_err_bit", userdata_in[1], 1);
        run_op(C_CLR_STATUS, 32'h0, 0, 0, 0, 0);
        run_op(C_GET_STATUS, 32'h0, 0, 0, 0, 0);
        check("status_cleared", userdata_in, 32'h0000_0700);
        run_op(C_WRITE, 32'h3333_4444, 1, 0, 0, 0);

        // Overrun during a beat, then an illegal opcode.
        run_op(C_WRITE, 32'h5555_6666, 4, 0, 0, 1);
        run_op(8'h5A, 32'h0, 0, 0, 0, 0);
        run_op(C_GET_STATUS, 32'h0, 0, 0, 0, 0);
        check("status_ovr_illegal", userdata_in, 32'h0000_5A18);

        // Randomized commands, with stray acks while idle.
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(negedge tck);
                bus_ack   = 1'b1;
                bus_err   = 1'b1;
                bus_rdata = $urandom();
                @(negedge tck);
                bus_ack = 1'b0;
                bus_err = 1'b0;
                check("stray_ack_req", bus_req, 0);
            end
            if ($urandom_range(0, 19) < 16) op = 8'($urandom_range(0, 7));
            else                             op = 8'($urandom_range(8, 255));
            rd = $urandom();
            run_op(op, $urandom(),
                   ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 6)),
                   ($urandom_range(0, 3) == 0), rd, 0);
        end
        run_op(C_GET_STATUS, 32'h0, 0, 0, 0, 0);

        // Pointer wrap at the top of the address space.
        run_op(C_SET_ADDR, 32'h0000_FFFF, 0, 0, 0, 0);
        run_op(C_READ_INC, 32'h0, 2, 0, 32'hA0A0_0B0B, 0);
        run_op(C_WRITE, 32'h0BAD_CAFE, 1, 0, 0, 0);

        // Asynchronous reset in the middle of a beat.
        @(negedge tck);
        userop       = C_WRITE;
        userdata_out = 32'hA5A5_5A5A;
        userop_ready = 1'b1;
        @(negedge tck);
        userop_ready = 1'b0;
        check("pre_rst_req", bus_req, 1);
        @(negedge tck);
        #2 trst = 1'b0;
        #1;
        check("mid_rst_bus_req", bus_req, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_bus_we", bus_we, 0);
        check("mid_rst_bus_addr", bus_addr, 0);
        check("mid_rst_bus_wdata", bus_wdata, 0);
        check("mid_rst_userdata_in", userdata_in, 0);
        @(negedge tck);
        trst = 1'b1;
        m_ptr = '0; m_ud = '0; m_last = '0;
        m_err = 0; m_timeout = 0; m_illegal = 0; m_overrun = 0;
        run_op(C_GET_STATUS, 32'h0, 0, 0, 0, 0);
        check("status_after_rst", userdata_in, 32'h0000_0000);
        run_op(C_READ, 32'h0, 1, 0, 32'h7777_8888, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
